// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared widths, FSM states and requester ids for ram_arbiter
package ram_arb_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD1  = 2'd2,
    RD2  = 2'd3
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - one requester's command/grant/read-return bundle
interface ram_arbiter_if #(
  parameter int ADDR_W = ram_arb_pkg::ADDR_W,
  parameter int DATA_W = ram_arb_pkg::DATA_W
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_arbiter_pick.sv
// rtl/ram_arbiter_pick.sv - 2-way picker: request vector plus priority id to one-hot grant
module ram_arb_pick (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);
  import ram_arb_pkg::*;

  always_comb begin
    gnt = 2'b00;
    if (req[REQ_A] && (!req[REQ_B] || prio == REQ_A)) begin
      gnt[REQ_A] = 1'b1;
    end else if (req[REQ_B]) begin
      gnt[REQ_B] = 1'b1;
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester sequencer for a single-port RAM with shared tristate bus
// RAM_ARB_RR_EN selects round-robin arbitration; otherwise A has fixed priority.
module ram_arbiter #(
  parameter int ADDR_W = ram_arb_pkg::ADDR_W,
  parameter int DATA_W = ram_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_arbiter_if.slave      a,
  ram_arbiter_if.slave      b,
  output logic              ram_en_write,
  output logic              ram_en_read,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data_io
);
  import ram_arb_pkg::*;

  state_t            state, state_nxt;
  logic [1:0]        req_vec, pick, gnt_vec;
  logic              prio;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              cmd_id;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rvalid_a, rvalid_b;
  logic [DATA_W-1:0] rdata_a, rdata_b;

  assign req_vec = {b.req, a.req};

  ram_arb_pick u_pick (
    .req  (req_vec),
    .prio (prio),
    .gnt  (pick)
  );

`ifdef RAM_ARB_RR_EN
  logic ptr;

  // Whoever was just served yields the tie-break to the other side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= REQ_A;
    end else if (|gnt_vec) begin
      ptr <= gnt_vec[REQ_A] ? REQ_B : REQ_A;
    end
  end

  assign prio = ptr;
`else
  assign prio = REQ_A;
`endif

  assign sel_we    = pick[REQ_B] ? b.we    : a.we;
  assign sel_addr  = pick[REQ_B] ? b.addr  : a.addr;
  assign sel_wdata = pick[REQ_B] ? b.wdata : a.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant is gated by rst_n so a held request cannot pulse gnt while reset is asserted.
  always_comb begin
    state_nxt    = state;
    gnt_vec      = 2'b00;
    ram_en_write = 1'b0;
    ram_en_read  = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && |pick) begin
          gnt_vec   = pick;
          state_nxt = sel_we ? WR : RD1;
        end
      end
      WR: begin
        ram_en_write = 1'b1;
        state_nxt    = IDLE;
      end
      RD1: begin
        ram_en_read = 1'b1;
        state_nxt   = RD2;
      end
      RD2: begin
        ram_en_read = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_id    <= REQ_A;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (|gnt_vec) begin
      cmd_id    <= pick[REQ_B];
      cmd_addr  <= sel_addr;
      cmd_wdata <= sel_wdata;
    end
  end

  // The RAM drives the bus during RD2; the word lands with the rvalid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      rdata_a  <= '0;
      rdata_b  <= '0;
    end else begin
      rvalid_a <= (state == RD2) && (cmd_id == REQ_A);
      rvalid_b <= (state == RD2) && (cmd_id == REQ_B);
      if (state == RD2 && cmd_id == REQ_A) rdata_a <= ram_data_io;
      if (state == RD2 && cmd_id == REQ_B) rdata_b <= ram_data_io;
    end
  end

  assign a.gnt    = gnt_vec[REQ_A];
  assign b.gnt    = gnt_vec[REQ_B];
  assign a.rvalid = rvalid_a;
  assign b.rvalid = rvalid_b;
  assign a.rdata  = rdata_a;
  assign b.rdata  = rdata_b;

  assign ram_addr    = cmd_addr;
  assign ram_data_io = (state == WR) ? cmd_wdata : 'z;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized and directed bench for ram_arbiter with a RAM model on the bus
module tb_ram_arbiter;
  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if ifa ();
  ram_arbiter_if ifb ();
  logic        ram_en_write, ram_en_read;
  logic [7:0]  ram_addr;
  wire  [31:0] ram_data_io;

  ram_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a            (ifa),
    .b            (ifb),
    .ram_en_write (ram_en_write),
    .ram_en_read  (ram_en_read),
    .ram_addr     (ram_addr),
    .ram_data_io  (ram_data_io)
  );

  // RAM: write at end of en_write cycle; read registers at end of first en_read
  // cycle and drives the bus for exactly the following cycle.
  logic [31:0] ram_mem [256];
  logic [31:0] ram_q;
  logic        ram_drv;
  logic        ram_clr;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= '0;
    end else if (ram_en_write) begin
      ram_mem[ram_addr] <= ram_data_io;
    end
    if (ram_en_read) ram_q <= ram_mem[ram_addr];
    ram_drv <= rst_n && ram_en_read && !ram_drv;
  end
  assign ram_data_io = ram_drv ? ram_q : 'z;

  int          vectors = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  cmd_t q_a[$];
  cmd_t q_b[$];
  cmd_t cur[2];
  logic cur_req[2];
  bit   granted[2];
  bit   rand_mode = 0;

  logic [31:0] mdl_mem [256];
  int          m_busy;
  logic        m_we, m_id, m_ptr, m_rv_a, m_rv_b;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata, m_rd_a, m_rd_b;

  bit          gnt_log[$];
  int unsigned a_gnt_cyc[$];
  int unsigned a_rd_gnt_cyc;
  int unsigned a_lat;
  int          a_rv_cnt, b_rv_cnt;
  logic [31:0] a_last, b_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic cmd_t mk(input logic we, input logic [7:0] addr, input logic [31:0] wdata);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = wdata;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    logic [7:0] ad;
    ad = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
    return mk(1'($urandom_range(0, 1)), ad, $urandom);
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < 2; i++) begin
      if (granted[i] || !cur_req[i]) begin
        cur_req[i] = 1'b0;
        if (i == 0 && q_a.size() > 0) begin
          cur[i] = q_a.pop_front(); cur_req[i] = 1'b1;
        end else if (i == 1 && q_b.size() > 0) begin
          cur[i] = q_b.pop_front(); cur_req[i] = 1'b1;
        end else if (rand_mode && $urandom_range(0, 2) != 0) begin
          cur[i] = rand_cmd(); cur_req[i] = 1'b1;
        end
      end
      granted[i] = 0;
    end
    ifa.req = cur_req[0]; ifa.we = cur[0].we; ifa.addr = cur[0].addr; ifa.wdata = cur[0].wdata;
    ifb.req = cur_req[1]; ifb.we = cur[1].we; ifb.addr = cur[1].addr; ifb.wdata = cur[1].wdata;
  endtask

  // Transaction-level model: a free cycle grants, then a write occupies 1 cycle and
  // a read 2 cycles, with the read word returned in the cycle after that.
  task automatic model_cycle();
    logic eg_a, eg_b, nra, nrb;
    cmd_t c;
    cyc++;
    if (!rst_n) begin
      chk("rst_gnt_a", ifa.gnt, 1'b0);
      chk("rst_gnt_b", ifb.gnt, 1'b0);
      chk("rst_rvalid_a", ifa.rvalid, 1'b0);
      chk("rst_rvalid_b", ifb.rvalid, 1'b0);
      chk("rst_en_write", ram_en_write, 1'b0);
      chk("rst_en_read", ram_en_read, 1'b0);
      chk("rst_addr", ram_addr, 8'h00);
      chk("rst_rdata_a", ifa.rdata, 32'h0);
      chk("rst_rdata_b", ifb.rdata, 32'h0);
      m_busy = 0; m_rv_a = 0; m_rv_b = 0; m_ptr = 0;
      m_rd_a = '0; m_rd_b = '0; m_addr = '0;
    end else begin
      eg_a = 0; eg_b = 0;
      if (m_busy == 0) begin
        if (cur_req[0] && cur_req[1]) begin
          if (m_ptr == 0) eg_a = 1; else eg_b = 1;
        end else begin
          eg_a = cur_req[0]; eg_b = cur_req[1];
        end
      end
      chk("gnt_a", ifa.gnt, eg_a);
      chk("gnt_b", ifb.gnt, eg_b);
      chk("rvalid_a", ifa.rvalid, m_rv_a);
      chk("rvalid_b", ifb.rvalid, m_rv_b);
      chk("en_write", ram_en_write, (m_busy > 0) && m_we);
      chk("en_read", ram_en_read, (m_busy > 0) && !m_we);
      chk("ram_addr", ram_addr, m_addr);
      chk("rdata_a", ifa.rdata, m_rd_a);
      chk("rdata_b", ifb.rdata, m_rd_b);
      if (m_busy > 0 && m_we) chk("bus_wdata", ram_data_io, m_wdata);
      if (m_busy == 1 && !m_we) chk("bus_rdata", ram_data_io, mdl_mem[m_addr]);

      if (ifa.gnt) begin
        granted[0] = 1; gnt_log.push_back(1'b0); a_gnt_cyc.push_back(cyc);
        if (!cur[0].we) a_rd_gnt_cyc = cyc;
      end
      if (ifb.gnt) begin
        granted[1] = 1; gnt_log.push_back(1'b1);
      end
      if (ifa.rvalid) begin a_rv_cnt++; a_last = ifa.rdata; a_lat = cyc - a_rd_gnt_cyc; end
      if (ifb.rvalid) begin b_rv_cnt++; b_last = ifb.rdata; end

      nra = 0; nrb = 0;
      if (m_busy > 0) begin
        if (m_we) begin
          mdl_mem[m_addr] = m_wdata;
        end else if (m_busy == 1) begin
          if (m_id == 0) begin m_rd_a = mdl_mem[m_addr]; nra = 1; end
          else begin m_rd_b = mdl_mem[m_addr]; nrb = 1; end
        end
        m_busy--;
      end else if (eg_a || eg_b) begin
        c = eg_b ? cur[1] : cur[0];
        m_id = eg_b; m_we = c.we; m_addr = c.addr; m_wdata = c.wdata;
        m_busy = c.we ? 1 : 2;
`ifdef RAM_ARB_RR_EN
        m_ptr = eg_a ? 1'b1 : 1'b0;
`endif
      end
      m_rv_a = nra; m_rv_b = nrb;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    drive_inputs();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic run_idle(input int max);
    bit done;
    done = 0;
    for (int n = 0; n < max && !done; n++) begin
      step();
      done = (q_a.size() == 0) && (q_b.size() == 0) && !cur_req[0] && !cur_req[1] &&
             (m_busy == 0) && !m_rv_a && !m_rv_b && !granted[0] && !granted[1];
    end
    chk("drain_done", done, 1'b1);
  endtask

  initial begin
    int base;
    bit got;
    cur_req[0] = 0; cur_req[1] = 0;
    cur[0] = mk(0, 0, 0); cur[1] = mk(0, 0, 0);
    granted[0] = 0; granted[1] = 0;
    ifa.req = 0; ifa.we = 0; ifa.addr = 0; ifa.wdata = 0;
    ifb.req = 0; ifb.we = 0; ifb.addr = 0; ifb.wdata = 0;
    for (int i = 0; i < 256; i++) mdl_mem[i] = '0;
    a_rv_cnt = 0; b_rv_cnt = 0; a_last = 0; b_last = 0; a_lat = 0; a_rd_gnt_cyc = 0;
    ram_clr = 1;
    rst_n = 0;
    // A held request during reset must not be granted.
    q_a.push_back(mk(1, 8'h05, 32'h5555AAAA));
    repeat (3) step();
    @(posedge clk); #1;
    ram_clr = 0; rst_n = 1;
    drive_inputs();
    @(negedge clk); model_cycle();
    run_idle(20);

    // A write then read of 0x10
    q_a.push_back(mk(1, 8'h10, 32'hDEADBEEF));
    q_a.push_back(mk(0, 8'h10, 32'h0));
    b_rv_cnt = 0;
    run_idle(40);
    chk("t2_rdata", a_last, 32'hDEADBEEF);
    chk("t2_latency", a_lat, 3);
    chk("t2_b_rvalid", b_rv_cnt, 0);

    // B write then read at the top address
    q_b.push_back(mk(1, 8'hFF, 32'h12345678));
    q_b.push_back(mk(0, 8'hFF, 32'h0));
    run_idle(40);
    chk("t4_rdata", b_last, 32'h12345678);

    // Both hammer reads: alternation under round-robin, A-first under fixed priority
    gnt_log.delete();
    for (int i = 0; i < 4; i++) begin
      q_a.push_back(mk(0, 8'(i), 32'h0));
      q_b.push_back(mk(0, 8'hFF, 32'h0));
    end
    run_idle(80);
    chk("t3_count", gnt_log.size(), 8);
    for (int i = 0; i < 8 && i < gnt_log.size(); i++) begin
`ifdef RAM_ARB_RR_EN
      chk($sformatf("t3_order%0d", i), gnt_log[i], 1'(i % 2));
`else
      chk($sformatf("t3_order%0d", i), gnt_log[i], (i >= 4) ? 1'b1 : 1'b0);
`endif
    end

    // Back-to-back A writes, then readback
    a_gnt_cyc.delete();
    for (int i = 0; i < 4; i++) q_a.push_back(mk(1, 8'(i), 32'hC0DE0000 + i));
    run_idle(40);
    chk("t6_gnts", a_gnt_cyc.size(), 4);
    for (int i = 1; i < 4 && i < a_gnt_cyc.size(); i++)
      chk($sformatf("t6_gap%0d", i), a_gnt_cyc[i] - a_gnt_cyc[i-1], 2);
    for (int i = 0; i < 4; i++) q_a.push_back(mk(0, 8'(i), 32'h0));
    run_idle(60);
    chk("t6_last", a_last, 32'hC0DE0003);

    // Reset in the middle of a read: aborted, no rvalid, no retry
    q_a.push_back(mk(0, 8'h10, 32'h0));
    got = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      step();
      got = granted[0];
    end
    chk("t1_granted", got, 1'b1);
    base = a_rv_cnt;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("t1_en_read", ram_en_read, 1'b0);
    chk("t1_en_write", ram_en_write, 1'b0);
    chk("t1_gnt_a", ifa.gnt, 1'b0);
    drive_inputs();
    @(negedge clk); model_cycle();
    step();
    @(posedge clk); #1;
    rst_n = 1;
    drive_inputs();
    @(negedge clk); model_cycle();
    run_idle(20);
    chk("t1_no_rvalid", a_rv_cnt, base);
    chk("t1_rdata_cleared", a_last, 32'hC0DE0003);

    // Randomized traffic on both requesters
    rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0;
    run_idle(50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
